axil_read_arbiter: RTL and testbench

- Shares one AXI-Lite read master port (AR + R channels) between NUM_REQ local requesters using round-robin arbitration.
- Sequences exactly one read at a time: grant, address phase, data phase, then a response pulse back to the granted requester.
- Sits between internal register-fetch clients and the bus-side read channel. It owns arvalid/rready generation.

---
 rtl/axil_read_arbiter.sv | 157 +++++++++++++++
 tb/tb_axil_read_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_read_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite read master (AR + R) between NUM_REQ clients.
// One read in flight at a time: grant, address phase, data phase, then a response pulse.
module axil_read_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_error,
    output logic                      busy,
    output logic [ADDR_W-1:0]         araddr,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [DATA_W-1:0]         rdata,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [1:0]                rresp
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       grant_next;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       last_grant_next;
    logic [ADDR_W-1:0]   araddr_next;
    logic                arvalid_next;
    logic                rready_next;
    logic [NUM_REQ-1:0]  req_ready_next;
    logic [NUM_REQ-1:0]  rsp_valid_next;
    logic [DATA_W-1:0]   rsp_data_next;
    logic                rsp_error_next;
    logic                busy_next;

    logic                pick_found;
    logic [GW-1:0]       pick_idx;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        logic [GW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((32'(last_grant) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        araddr_next     = araddr;
        arvalid_next    = arvalid;
        rready_next     = rready;
        req_ready_next  = '0;
        rsp_valid_next  = '0;
        rsp_data_next   = rsp_data;
        rsp_error_next  = rsp_error;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_next               = pick_idx;
                    araddr_next              = addr_arr[pick_idx];
                    arvalid_next             = 1'b1;
                    req_ready_next[pick_idx] = 1'b1;
                    state_next               = ADDR;
                end
            end
            ADDR: begin
                if (arvalid && arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (rvalid && rready) begin
                    rsp_data_next         = rdata;
                    rsp_error_next        = (rresp != 2'b00);
                    rready_next           = 1'b0;
                    rsp_valid_next[grant] = 1'b1;
                    last_grant_next       = grant;
                    state_next            = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            grant      <= grant_next;
            last_grant <= last_grant_next;
            araddr     <= araddr_next;
            arvalid    <= arvalid_next;
            rready     <= rready_next;
            req_ready  <= req_ready_next;
            rsp_valid  <= rsp_valid_next;
            rsp_data   <= rsp_data_next;
            rsp_error  <= rsp_error_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Bench for axil_read_arbiter: directed vector table, reset corner cases, and
// randomized transactions checked against a transaction-level round-robin model.
module tb_axil_read_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_error;
    logic            busy;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic            rvalid;
    logic            rready;
    logic [1:0]      rresp;

    axil_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .busy      (busy),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .rresp     (rresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] rv;
        logic [31:0]  base;
        int           ard;
        int           rd;
        logic [31:0]  data;
        logic [1:0]   resp;
        int           exp_g;
        logic [31:0]  exp_addr;
        logic         exp_err;
        bit           hold;
    } vec_t;

    vec_t vecs [12];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   m_last = N - 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration rule: first requester after the last completed grant.
    function automatic int rr_pick(input int last, input logic [N-1:0] mask);
        for (int k = 1; k <= int'(N); k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic set_addrs(input logic [31:0] base);
        for (int i = 0; i < int'(N); i++) req_addr[i*AW +: AW] = base + 32'(i) * 32'h100;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_arvalid"}, 64'(arvalid), 64'(0));
        chk({tag, "_rready"}, 64'(rready), 64'(0));
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // One full read: grant edge, optional AR stall, optional R stall, response, back to idle.
    task automatic run_txn(input vec_t v);
        logic [N-1:0] oh;
        oh = '0;
        oh[v.exp_g] = 1'b1;
        req_valid = v.rv;
        set_addrs(v.base);
        arready = 1'b0;
        rvalid  = 1'b0;
        step();
        chk("grant_req_ready", 64'(req_ready), 64'(oh));
        chk("grant_arvalid", 64'(arvalid), 64'(1));
        chk("grant_araddr", 64'(araddr), 64'(v.exp_addr));
        chk("grant_busy", 64'(busy), 64'(1));
        if (!v.hold) begin
            req_valid = N'($urandom);
            set_addrs($urandom);
        end
        for (int k = 0; k < v.ard; k++) begin
            step();
            chk("astall_arvalid", 64'(arvalid), 64'(1));
            chk("astall_araddr", 64'(araddr), 64'(v.exp_addr));
            chk("astall_rready", 64'(rready), 64'(0));
            chk("astall_req_ready", 64'(req_ready), 64'(0));
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("data_arvalid", 64'(arvalid), 64'(0));
        chk("data_rready", 64'(rready), 64'(1));
        chk("data_req_ready", 64'(req_ready), 64'(0));
        for (int k = 0; k < v.rd; k++) begin
            rdata = $urandom;
            rresp = 2'($urandom);
            step();
            chk("rstall_rready", 64'(rready), 64'(1));
            chk("rstall_rsp_valid", 64'(rsp_valid), 64'(0));
        end
        rvalid = 1'b1;
        rdata  = v.data;
        rresp  = v.resp;
        step();
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'($urandom);
        if (!v.hold) req_valid = '0;
        chk("resp_rsp_valid", 64'(rsp_valid), 64'(oh));
        chk("resp_rsp_data", 64'(rsp_data), 64'(v.data));
        chk("resp_rsp_error", 64'(rsp_error), 64'(v.exp_err));
        chk("resp_rready", 64'(rready), 64'(0));
        chk("resp_busy", 64'(busy), 64'(1));
        step();
        chk("done_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_rsp_data_hold", 64'(rsp_data), 64'(v.data));
        chk("done_rsp_error_hold", 64'(rsp_error), 64'(v.exp_err));
        m_last = v.exp_g;
    endtask

    initial begin
        vec_t v;
        logic [N-1:0] oh;

        vecs[0]  = '{4'b0001, 32'h0000_0010, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 32'h0000_0010, 1'b0, 1'b0};
        vecs[1]  = '{4'b0011, 32'h0000_0100, 0, 0, 32'h1111_0001, 2'b00, 1, 32'h0000_0200, 1'b0, 1'b1};
        vecs[2]  = '{4'b0011, 32'h0000_0100, 0, 0, 32'h2222_0002, 2'b00, 0, 32'h0000_0100, 1'b0, 1'b1};
        vecs[3]  = '{4'b0011, 32'h0000_0100, 1, 0, 32'h3333_0003, 2'b00, 1, 32'h0000_0200, 1'b0, 1'b1};
        vecs[4]  = '{4'b0011, 32'h0000_0100, 5, 3, 32'hCAFE_F00D, 2'b00, 0, 32'h0000_0100, 1'b0, 1'b1};
        vecs[5]  = '{4'b0010, 32'h0000_4000, 0, 0, 32'h0000_1234, 2'b10, 1, 32'h0000_4100, 1'b1, 1'b0};
        vecs[6]  = '{4'b1010, 32'h0000_0000, 2, 1, 32'h5555_AAAA, 2'b01, 3, 32'h0000_0300, 1'b1, 1'b0};
        vecs[7]  = '{4'b1010, 32'h0000_0000, 0, 2, 32'h0BAD_CAFE, 2'b00, 1, 32'h0000_0100, 1'b0, 1'b0};
        vecs[8]  = '{4'b0100, 32'h8000_0000, 1, 0, 32'hFFFF_FFFF, 2'b11, 2, 32'h8000_0200, 1'b1, 1'b0};
        vecs[9]  = '{4'b1111, 32'h0000_1000, 0, 0, 32'h0000_0000, 2'b00, 3, 32'h0000_1300, 1'b0, 1'b1};
        vecs[10] = '{4'b1111, 32'h0000_1000, 0, 1, 32'h7777_8888, 2'b00, 0, 32'h0000_1000, 1'b0, 1'b1};
        vecs[11] = '{4'b1001, 32'h0000_2000, 3, 0, 32'h9999_0000, 2'b00, 3, 32'h0000_2300, 1'b0, 1'b0};

        req_valid = '0;
        req_addr  = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        do_reset();

        check_quiet("reset");
        chk("reset_araddr", 64'(araddr), 64'(0));
        chk("reset_rsp_data", 64'(rsp_data), 64'(0));
        chk("reset_rsp_error", 64'(rsp_error), 64'(0));

        for (int c = 0; c < 10; c++) begin
            step();
            check_quiet("idle");
        end

        for (int i = 0; i < 12; i++) run_txn(vecs[i]);

        // Reset while waiting for R data: abort with no response, priority back to requester 0.
        v = '{4'b0001, 32'h0000_0040, 0, 0, 32'h4444_4444, 2'b00, 0, 32'h0000_0040, 1'b0, 1'b0};
        run_txn(v);
        req_valid = 4'b0011;
        set_addrs(32'h0000_0500);
        step();
        chk("abort_req_ready", 64'(req_ready), 64'(4'b0010));
        chk("abort_araddr", 64'(araddr), 64'(32'h0000_0600));
        req_valid = '0;
        arready   = 1'b1;
        step();
        arready = 1'b0;
        chk("abort_rready", 64'(rready), 64'(1));
        rvalid = 1'b1;
        rdata  = 32'hABCD_0000;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        rvalid = 1'b0;
        check_quiet("abort");
        step();
        check_quiet("abort_after");
        m_last = N - 1;
        v = '{4'b0011, 32'h0000_0700, 0, 0, 32'h6666_0000, 2'b00, 0, 32'h0000_0700, 1'b0, 1'b0};
        run_txn(v);

        // Randomized traffic against the round-robin model.
        for (int r = 0; r < 250; r++) begin
            logic [N-1:0] rv;
            rv = N'($urandom);
            if (rv == '0) begin
                req_valid = '0;
                set_addrs($urandom);
                for (int c = 0; c < 3; c++) begin
                    step();
                    check_quiet("rnd_idle");
                end
            end else begin
                v.rv       = rv;
                v.base     = $urandom;
                v.ard      = int'($urandom_range(0, 4));
                v.rd       = int'($urandom_range(0, 4));
                v.data     = $urandom;
                v.resp     = 2'($urandom);
                v.exp_g    = rr_pick(m_last, rv);
                v.exp_addr = v.base + 32'(v.exp_g) * 32'h100;
                v.exp_err  = (v.resp != 2'b00);
                v.hold     = 1'($urandom);
                run_txn(v);
            end
        end

        oh = '0;
        req_valid = '0;
        step();
        chk("final_rsp_valid", 64'(rsp_valid), 64'(oh));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
